sm4_key_expander: RTL and testbench
===================================

Name: sm4_key_expander

Overview:
Sequential SM4 key schedule. Takes a 128-bit master key and produces all 32 round keys rk0..rk31, computing ROUNDS_PER_CYCLE rounds each clock with that many T' (tau then L') units. Round keys are streamed out as they are produced and kept in an internal register file. The cipher datapath reads them by index in encrypt or decrypt order, so it sits between the key CSRs and the SM4 round engine of the accelerator.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds per clock; legal values 1, 2, 4, 8 (divides 32); elaboration error otherwise.
STORE_KEYS, 1, 1 = keep the 32x32 round-key register file and read port; 0 = stream only, read port ties to 0.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; load master key and begin expansion
mk  in  128  master key, MK0 = mk[127:96] ... MK3 = mk[31:0]; sampled on the accepted start
zeroize  in  1  synchronous clear of all key state; highest priority
busy  out  1  expansion in progress
key_valid  out  1  all 32 round keys stored and current
rk_out  out  32*ROUNDS_PER_CYCLE  round keys produced this cycle; lane j = rk(base+j), lane 0 in LSBs
rk_out_valid  out  1  rk_out holds new keys
rk_out_base  out  5  index of lane 0
rd_addr  in  5  round-key read index
rd_dec  in  1  0 = read rk[rd_addr]; 1 = read rk[31-rd_addr]
rd_data  out  32  combinational read; 0 when key_valid=0 or STORE_KEYS=0

Behaviour:
- Reset values: busy=0, key_valid=0, rk_out=0, rk_out_valid=0, rk_out_base=0. The register file and K0..K3 state are cleared to 0.
- States are IDLE, EXPAND and DONE. DONE is a sticky form of IDLE in which key_valid=1.
- Start is accepted in IDLE or DONE. On acceptance:
  - K0..K3 <= MKi ^ FKi, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - round counter <= 0, key_valid <= 0, go to EXPAND.
- Start while busy=1 is ignored; the running expansion is unaffected.
- Each EXPAND cycle computes N = ROUNDS_PER_CYCLE chained rounds from i = counter:
  - rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i), and the K window shifts by one per round.
  - CK_i byte j (MSB first) = ((4i+j)*7) mod 256.
  - T'(x) = L'(tau(x)), where tau is the byte-wise SM4 S-box and L'(b) = b ^ (b<<<13) ^ (b<<<23).
- Registered outputs: rk_out, rk_out_base=i and rk_out_valid=1 appear the cycle after computation. The register file is written the same edge.
- The counter advances by N each cycle and wraps to 0 after 32.
- After the last group:
  - busy goes to 0 and key_valid goes to 1, in the same cycle as the final rk_out_valid.
  - Total latency from accepted start to key_valid=1 is 32/N cycles, e.g. 32 for N=1 and 8 for N=4.
- rk_out_valid is high for exactly 32/N consecutive cycles per expansion.
- zeroize (any state):
  - next edge clears K state, the register file, rk_out and the counter.
  - busy=0, key_valid=0, next state IDLE.
  - zeroize together with start: zeroize wins and start is dropped.
- Reset mid-expansion: all outputs go to their reset values immediately (asynchronous); no partial keys remain visible.
- rd_data changes with rd_addr and rd_dec in the same cycle (no pipeline stage).

Decomposition:
- Shared package sm4_pkg holds:
  - the FK constant array.
  - a function that computes CK_i from i.
  - rotl32.
  - the round-key count constant 32.
- The S-box stays the existing sbox_replace.
- One natural sub-module, sm4_key_round: a combinational single round (inputs K_i..K_{i+3} and i; outputs rk_i). It is instantiated ROUNDS_PER_CYCLE times in a chain inside a generate loop.

Test Plan:
- Standard vector, N=1: mk=0123456789ABCDEFFEDCBA9876543210, start -> rk0=F12186F9 at rk_out_base=0. key_valid rises 32 cycles after start. rd_addr=31, rd_dec=0 gives 9124A012; rd_addr=0, rd_dec=1 gives 9124A012.
- Same vector with N=4 and N=8 -> identical register-file contents. key_valid at 8 and 4 cycles; rk_out_valid high for 8 and 4 cycles respectively.
- Start re-pulsed at cycle 5 of an expansion -> ignored; final keys still match the standard vector and key_valid appears on schedule.
- zeroize at cycle 10, then again in DONE -> busy=0, key_valid=0, rd_data=0 on all 32 addresses, rk_out=0. A following start with mk=0 must match the golden-model keys.
- rst_n asserted mid-expansion -> all outputs are 0 without waiting for a clk edge. After release, a new start completes correctly.
- Back-to-back: start accepted in the same cycle key_valid rises (DONE) -> key_valid drops the next cycle. The second key set matches the golden model, with no mixing of round keys from the first set.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants and helpers: FK words, CK generation,
// 32-bit rotate and the expander state encoding.
package sm4_pkg;

   localparam int RK_NUM = 32;

   localparam logic [0:3][31:0] FK = {32'hA3B1BAC6, 32'h56AA3350,
                                      32'h677D9197, 32'hB27022DC};

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} ks_state_t;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // CK_i byte j (MSB first) is ((4i+j)*7) mod 256; the 8-bit cast does the mod.
   function automatic logic [31:0] ck_word(input logic [4:0] i);
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((int'(i) * 4 + j) * 7);
      return w;
   endfunction

endpackage

// File: rtl/sbox_replace.sv
// SM4 byte substitution (tau on one byte), purely combinational table lookup.
module sbox_replace (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [0:255][7:0] SBOX = {
      128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
      128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
      128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
      128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
      128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
      128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
      128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
      128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
   };

   assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-schedule round: rk_i = K_i ^ T'(K_i+1 ^ K_i+2 ^ K_i+3 ^ CK_i).
module sm4_key_round
   import sm4_pkg::*;
(
   input  logic [31:0] i_k0,
   input  logic [31:0] i_k1,
   input  logic [31:0] i_k2,
   input  logic [31:0] i_k3,
   input  logic [4:0]  i_idx,
   output logic [31:0] o_rk
);

   logic [31:0] w_x;
   logic [31:0] w_b;

   assign w_x = i_k1 ^ i_k2 ^ i_k3 ^ ck_word(i_idx);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      sbox_replace u_sbox (
         .i_byte (w_x[8*b +: 8]),
         .o_byte (w_b[8*b +: 8])
      );
   end

   assign o_rk = i_k0 ^ w_b ^ rotl32(w_b, 13) ^ rotl32(w_b, 23);

endmodule

// File: rtl/sm4_key_expander.sv
// Iterative SM4 key schedule: ROUNDS_PER_CYCLE chained rounds per clock,
// streams round keys out and optionally holds them in a readable register file.
module sm4_key_expander
   import sm4_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit STORE_KEYS       = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [127:0]                   mk,
   input  logic                           zeroize,
   output logic                           busy,
   output logic                           key_valid,
   output logic [32*ROUNDS_PER_CYCLE-1:0] rk_out,
   output logic                           rk_out_valid,
   output logic [4:0]                     rk_out_base,
   input  logic [4:0]                     rd_addr,
   input  logic                           rd_dec,
   output logic [31:0]                    rd_data
);

   localparam int         N         = ROUNDS_PER_CYCLE;
   localparam logic [4:0] LAST_BASE = 5'(RK_NUM - N);

   if (!(N == 1 || N == 2 || N == 4 || N == 8)) begin : g_bad_n
      $error("sm4_key_expander: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   ks_state_t        r_state;
   ks_state_t        w_next;
   logic [31:0]      r_k [0:3];
   logic [4:0]       r_cnt;
   logic [32*N-1:0]  r_rk_out;
   logic             r_rk_out_valid;
   logic [4:0]       r_rk_out_base;
   logic [31:0]      w_k [0:N+3];
   logic [32*N-1:0]  w_rk;
   logic             w_start_ok;
   logic             w_step;
   logic             w_last;

   assign w_start_ok = start && !zeroize && (r_state != ST_EXPAND);
   assign w_step     = (r_state == ST_EXPAND);
   assign w_last     = w_step && (r_cnt == LAST_BASE);

   // w_k[j..j+3] is the K window seen by round j; round j appends K_{i+j+4}.
   for (genvar i = 0; i < 4; i++) begin : g_win
      assign w_k[i] = r_k[i];
   end

   for (genvar j = 0; j < N; j++) begin : g_round
      sm4_key_round u_round (
         .i_k0  (w_k[j]),
         .i_k1  (w_k[j+1]),
         .i_k2  (w_k[j+2]),
         .i_k3  (w_k[j+3]),
         .i_idx (r_cnt + 5'(j)),
         .o_rk  (w_k[j+4])
      );
      assign w_rk[32*j +: 32] = w_k[j+4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (zeroize) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_EXPAND;
            ST_EXPAND:        if (w_last) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state == ST_EXPAND);
      key_valid = (r_state == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_k[i] <= '0;
         r_cnt          <= '0;
         r_rk_out       <= '0;
         r_rk_out_valid <= 1'b0;
         r_rk_out_base  <= '0;
      end else if (zeroize) begin
         for (int i = 0; i < 4; i++) r_k[i] <= '0;
         r_cnt          <= '0;
         r_rk_out       <= '0;
         r_rk_out_valid <= 1'b0;
         r_rk_out_base  <= '0;
      end else begin
         r_rk_out_valid <= w_step;
         if (w_start_ok) begin
            for (int i = 0; i < 4; i++) r_k[i] <= mk[127-32*i -: 32] ^ FK[i];
            r_cnt <= '0;
         end else if (w_step) begin
            for (int i = 0; i < 4; i++) r_k[i] <= w_k[N+i];
            r_cnt         <= r_cnt + 5'(N);
            r_rk_out      <= w_rk;
            r_rk_out_base <= r_cnt;
         end
      end
   end

   assign rk_out       = r_rk_out;
   assign rk_out_valid = r_rk_out_valid;
   assign rk_out_base  = r_rk_out_base;

   if (STORE_KEYS) begin : g_rf
      logic [31:0] r_rf [0:RK_NUM-1];
      logic [4:0]  w_rd_idx;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int a = 0; a < RK_NUM; a++) r_rf[a] <= '0;
         end else if (zeroize) begin
            for (int a = 0; a < RK_NUM; a++) r_rf[a] <= '0;
         end else if (w_step) begin
            for (int j = 0; j < N; j++) r_rf[r_cnt + 5'(j)] <= w_k[j+4];
         end
      end

      // Decrypt order reads rk[31-addr], which is the bitwise complement in 5 bits.
      assign w_rd_idx = rd_dec ? ~rd_addr : rd_addr;
      assign rd_data  = key_valid ? r_rf[w_rd_idx] : '0;
   end else begin : g_no_rf
      assign rd_data = '0;
   end

endmodule

// File: tb/tb_sm4_key_expander.sv
// Runs N=1, 4 and 8 expanders in lockstep against a scoreboard fed by an
// independent SM4 key-schedule model.
module tb_sm4_key_expander;

   localparam int NL [3] = '{1, 4, 8};
   localparam logic [127:0] MK_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [2047:0] SB = {
      128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
      128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
      128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
      128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
      128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
      128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
      128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
      128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
   };

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] mk = '0;
   logic         zeroize = 1'b0;
   logic [4:0]   rd_addr = '0;
   logic         rd_dec = 1'b0;

   logic         busy_v [3];
   logic         kv_v [3];
   logic         rvld_v [3];
   logic [4:0]   base_v [3];
   logic [31:0]  rd_v [3];
   logic [255:0] rko_v [3];

   logic [36:0]  sbq [3][$];
   logic [31:0]  gk [32];
   int           n_vec = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int NS = (k == 0) ? 1 : (k == 1) ? 4 : 8;
      logic [32*NS-1:0] w_rko;
      sm4_key_expander #(.ROUNDS_PER_CYCLE(NS), .STORE_KEYS(1'b1)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start        (start),
         .mk           (mk),
         .zeroize      (zeroize),
         .busy         (busy_v[k]),
         .key_valid    (kv_v[k]),
         .rk_out       (w_rko),
         .rk_out_valid (rvld_v[k]),
         .rk_out_base  (base_v[k]),
         .rd_addr      (rd_addr),
         .rd_dec       (rd_dec),
         .rd_data      (rd_v[k])
      );
      assign rko_v[k] = 256'(w_rko);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SB[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [31:0] tp(input logic [31:0] x);
      logic [31:0] b;
      b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   task automatic gold(input logic [127:0] m);
      logic [31:0] kk [36];
      logic [31:0] fk [4];
      logic [31:0] ck;
      fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
      for (int i = 0; i < 4; i++) kk[i] = m[127-32*i -: 32] ^ fk[i];
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4*i) * 7), 8'((4*i+1) * 7), 8'((4*i+2) * 7), 8'((4*i+3) * 7)};
         kk[i+4] = kk[i] ^ tp(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
         gk[i] = kk[i+4];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s busy N%0d", tag, NL[k]), 64'(busy_v[k]), 64'd0);
         chk($sformatf("%s key_valid N%0d", tag, NL[k]), 64'(kv_v[k]), 64'd0);
         chk($sformatf("%s rk_out_valid N%0d", tag, NL[k]), 64'(rvld_v[k]), 64'd0);
         chk($sformatf("%s rk_out_base N%0d", tag, NL[k]), 64'(base_v[k]), 64'd0);
         chk($sformatf("%s rk_out N%0d", tag, NL[k]), 64'(rko_v[k] != '0), 64'd0);
         chk($sformatf("%s rd_data N%0d", tag, NL[k]), 64'(rd_v[k]), 64'd0);
      end
   endtask

   task automatic do_start(input logic [127:0] m);
      gold(m);
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) sbq[k].push_back({5'(i), gk[i]});
      mk = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("accept busy N%0d", NL[k]), 64'(busy_v[k]), 64'd1);
         chk($sformatf("accept key_valid N%0d", NL[k]), 64'(kv_v[k]), 64'd0);
      end
   endtask

   // Cycle c counts clock edges after the accepting edge; ign_at injects an ignored start.
   task automatic wait_expand(input int ncyc, input int ign_at);
      for (int c = 1; c <= ncyc; c++) begin
         if (c == ign_at) begin
            mk = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy N%0d c%0d", NL[k], c), 64'(busy_v[k]), 64'(c < 32 / NL[k]));
            chk($sformatf("key_valid N%0d c%0d", NL[k], c), 64'(kv_v[k]), 64'(c >= 32 / NL[k]));
         end
      end
   endtask

   task automatic rd_sweep(input bit zero);
      for (int a = 0; a < 32; a++) begin
         for (int d = 0; d < 2; d++) begin
            rd_addr = 5'(a);
            rd_dec = d[0];
            #1;
            for (int k = 0; k < 3; k++)
               chk($sformatf("rd N%0d a%0d d%0d", NL[k], a, d), 64'(rd_v[k]),
                   zero ? 64'd0 : 64'(gk[d ? 31 - a : a]));
         end
      end
   endtask

   always @(negedge clk) begin
      logic [36:0] e;
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (rvld_v[k]) begin
               for (int j = 0; j < NL[k]; j++) begin
                  if (sbq[k].size() == 0) begin
                     chk($sformatf("sb_extra N%0d", NL[k]), 64'd1, 64'd0);
                  end else begin
                     e = sbq[k].pop_front();
                     chk($sformatf("rk N%0d idx%0d", NL[k], e[36:32]),
                         64'({base_v[k] + 5'(j), rko_v[k][32*j +: 32]}), 64'(e));
                  end
               end
            end
         end
      end
   end

   initial begin
      tick();
      tick();
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();

      // Standard vector with known-answer read-backs in both orders.
      do_start(MK_STD);
      wait_expand(32, 0);
      rd_addr = 5'd31; rd_dec = 1'b0; #1;
      for (int k = 0; k < 3; k++) chk($sformatf("kat rk31 N%0d", NL[k]), 64'(rd_v[k]), 64'h9124A012);
      rd_addr = 5'd0; rd_dec = 1'b1; #1;
      for (int k = 0; k < 3; k++) chk($sformatf("kat dec0 N%0d", NL[k]), 64'(rd_v[k]), 64'h9124A012);
      rd_addr = 5'd0; rd_dec = 1'b0; #1;
      for (int k = 0; k < 3; k++) chk($sformatf("kat rk0 N%0d", NL[k]), 64'(rd_v[k]), 64'hF12186F9);
      rd_sweep(1'b0);
      tick();

      // Re-pulsed start while busy must be ignored.
      do_start(MK_STD);
      wait_expand(32, 3);
      rd_sweep(1'b0);
      tick();

      // Back-to-back: second start lands in the cycle key_valid rises for N=1.
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(32, 0);
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(32, 0);
      rd_sweep(1'b0);
      tick();

      // Zeroize mid-expansion, then mk=0, then zeroize in DONE.
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(9, 0);
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      for (int k = 0; k < 3; k++) sbq[k].delete();
      chk_quiet("zeroize_mid");
      rd_sweep(1'b1);
      tick();
      do_start(128'd0);
      wait_expand(32, 0);
      rd_sweep(1'b0);
      zeroize = 1'b1;
      mk = MK_STD;
      start = 1'b1;
      tick();
      zeroize = 1'b0;
      start = 1'b0;
      chk_quiet("zeroize_done");
      tick();
      chk_quiet("zeroize_hold");

      // Asynchronous reset mid-expansion, between clock edges.
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(5, 0);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) sbq[k].delete();
      chk_quiet("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(32, 0);
      rd_sweep(1'b0);
      tick();

      for (int k = 0; k < 3; k++)
         chk($sformatf("sb_left N%0d", NL[k]), 64'(sbq[k].size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
